// File: rtl/bnn_layer_pkg.sv
// Shared types and sizing helpers for the binary conv3x3 + threshold + 2x2 max-pool layer.
package bnn_layer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StDone
  } state_e;

  // Bits needed to hold a count in 0..n.
  function automatic int unsigned popcount_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Pooled side for a valid 3x3 conv followed by a floor 2x2 pool.
  function automatic int unsigned pool_size(input int unsigned in_size);
    return (in_size - 2) / 2;
  endfunction

endpackage

// File: rtl/bnn_xnor_window.sv
// Combinational XNOR-popcount of one IC x 3x3 window against one kernel.
module bnn_xnor_window #(
  parameter int unsigned IC   = 4,
  parameter int unsigned PopW = 6
) (
  input  logic [IC*9-1:0] win_i,
  input  logic [IC*9-1:0] kern_i,
  output logic [PopW-1:0] pop_o
);

  logic [IC*9-1:0] match;

  assign match = ~(win_i ^ kern_i);

  // Count agreeing bits between window and kernel
  always_comb begin
    pop_o = '0;
    for (int i = 0; i < int'(IC * 9); i++) begin
      pop_o = pop_o + PopW'(match[i]);
    end
  end

endmodule

// File: rtl/bnn_conv_pool_layer.sv
// Binary conv3x3 + per-channel threshold + 2x2 max-pool, LANES output channels per cycle.
// Optional build macro BNN_THRESH_FLIP_EN adds a per-channel comparison flip (thresh_flip).
module bnn_conv_pool_layer
  import bnn_layer_pkg::*;
#(
  parameter int unsigned IC            = 4,
  parameter int unsigned OC            = 8,
  parameter int unsigned LANES         = 2,
  parameter int unsigned IMG_IN_SIZE   = 30,
  parameter int unsigned THRESH_W      = popcount_w(IC * 9),
  localparam int unsigned CONV_OUT_SIZE = IMG_IN_SIZE - 2,
  localparam int unsigned POOL_OUT_SIZE = CONV_OUT_SIZE / 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]       img_in [IC],
  input  logic [IC*9-1:0]                          weights [OC],
  input  logic [THRESH_W-1:0]                      thresh [OC],
`ifdef BNN_THRESH_FLIP_EN
  input  logic                                     thresh_flip [OC],
`endif
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [POOL_OUT_SIZE*POOL_OUT_SIZE-1:0]   img_out [OC],
  output logic                                     busy
);

  localparam int unsigned ImgSq   = IMG_IN_SIZE * IMG_IN_SIZE;
  localparam int unsigned PoolSq  = POOL_OUT_SIZE * POOL_OUT_SIZE;
  localparam int unsigned KernW   = IC * 9;
  localparam int unsigned NGrp    = OC / LANES;
  localparam int unsigned GrpW    = (NGrp > 1) ? $clog2(NGrp) : 1;
  localparam int unsigned PosW    = (POOL_OUT_SIZE > 1) ? $clog2(POOL_OUT_SIZE) : 1;
  localparam int unsigned ChW     = (OC > 1) ? $clog2(OC) : 1;
  localparam int unsigned PixW    = (PoolSq > 1) ? $clog2(PoolSq) : 1;
  localparam int unsigned ImgIdxW = (ImgSq > 1) ? $clog2(ImgSq) : 1;
  localparam int unsigned PopW    = popcount_w(KernW);

  localparam logic [GrpW-1:0] GrpLast = GrpW'(NGrp - 1);
  localparam logic [PosW-1:0] PosLast = PosW'(POOL_OUT_SIZE - 1);

  state_e                    state_q, state_d;
  logic [GrpW-1:0]           grp_q, grp_d;
  logic [PosW-1:0]           prow_q, prow_d;
  logic [PosW-1:0]           pcol_q, pcol_d;
  logic [ImgSq-1:0]          img_q [IC];
  logic [ImgSq-1:0]          img_d [IC];
  logic [KernW-1:0]          w_q [OC];
  logic [KernW-1:0]          w_d [OC];
  logic [THRESH_W-1:0]       thr_q [OC];
  logic [THRESH_W-1:0]       thr_d [OC];
  logic [PoolSq-1:0]         out_q [OC];
  logic [PoolSq-1:0]         out_d [OC];
`ifdef BNN_THRESH_FLIP_EN
  logic                      flip_q [OC];
  logic                      flip_d [OC];
`endif

  logic [3:0][KernW-1:0]     win;
  logic [LANES-1:0][ChW-1:0] lane_ch;
  logic [LANES-1:0]          pool_bit;
  logic [PixW-1:0]           pix_idx;

  assign pix_idx = PixW'(32'(prow_q) * POOL_OUT_SIZE + 32'(pcol_q));

  // The four conv windows of the current pool cell are shared by every lane.
  for (genvar q = 0; q < 4; q++) begin : g_win
    localparam int unsigned Dr = q / 2;
    localparam int unsigned Dc = q % 2;
    logic [ImgIdxW-1:0] base;
    assign base = ImgIdxW'((2 * 32'(prow_q) + Dr) * IMG_IN_SIZE + 2 * 32'(pcol_q) + Dc);
    for (genvar ic = 0; ic < IC; ic++) begin : g_ic
      for (genvar kr = 0; kr < 3; kr++) begin : g_kr
        for (genvar kc = 0; kc < 3; kc++) begin : g_kc
          assign win[q][ic*9+kr*3+kc] =
              img_q[ic][base + ImgIdxW'(kr * IMG_IN_SIZE + kc)];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] hit;
    assign lane_ch[l] = ChW'(32'(grp_q) * LANES + l);
    for (genvar q = 0; q < 4; q++) begin : g_pix
      logic [PopW-1:0] pop;
      bnn_xnor_window #(
        .IC   (IC),
        .PopW (PopW)
      ) u_win (
        .win_i  (win[q]),
        .kern_i (w_q[lane_ch[l]]),
        .pop_o  (pop)
      );
`ifdef BNN_THRESH_FLIP_EN
      assign hit[q] = flip_q[lane_ch[l]] ? (32'(pop) <  32'(thr_q[lane_ch[l]]))
                                         : (32'(pop) >= 32'(thr_q[lane_ch[l]]));
`else
      assign hit[q] = 32'(pop) >= 32'(thr_q[lane_ch[l]]);
`endif
    end
    assign pool_bit[l] = |hit;
  end

  // Next-state, capture and handshake outputs
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    prow_d    = prow_q;
    pcol_d    = pcol_q;
    img_d     = img_q;
    w_d       = w_q;
    thr_d     = thr_q;
    out_d     = out_q;
`ifdef BNN_THRESH_FLIP_EN
    flip_d    = flip_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          img_d  = img_in;
          w_d    = weights;
          thr_d  = thresh;
`ifdef BNN_THRESH_FLIP_EN
          flip_d = thresh_flip;
`endif
          for (int i = 0; i < int'(OC); i++) out_d[i] = '0;
          grp_d   = '0;
          prow_d  = '0;
          pcol_d  = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        busy = 1'b1;
        for (int l = 0; l < int'(LANES); l++) out_d[lane_ch[l]][pix_idx] = pool_bit[l];
        // pcol fastest, then prow, then channel group
        if (pcol_q == PosLast) begin
          pcol_d = '0;
          if (prow_q == PosLast) begin
            prow_d = '0;
            if (grp_q == GrpLast) begin
              grp_d   = '0;
              state_d = StDone;
            end else begin
              grp_d = grp_q + GrpW'(1);
            end
          end else begin
            prow_d = prow_q + PosW'(1);
          end
        end else begin
          pcol_d = pcol_q + PosW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and captured bundle; reset discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grp_q   <= '0;
      prow_q  <= '0;
      pcol_q  <= '0;
      for (int i = 0; i < int'(IC); i++) img_q[i] <= '0;
      for (int i = 0; i < int'(OC); i++) begin
        w_q[i]    <= '0;
        thr_q[i]  <= '0;
        out_q[i]  <= '0;
`ifdef BNN_THRESH_FLIP_EN
        flip_q[i] <= 1'b0;
`endif
      end
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      prow_q  <= prow_d;
      pcol_q  <= pcol_d;
      img_q   <= img_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
      out_q   <= out_d;
`ifdef BNN_THRESH_FLIP_EN
      flip_q  <= flip_d;
`endif
    end
  end

  assign img_out = out_q;

endmodule

// File: tb/tb_bnn_conv_pool_layer.sv
// Directed bench for bnn_conv_pool_layer: three instances (small 6x6, odd 7x7, default 30x30).
module tb_bnn_conv_pool_layer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int lat;

  // Instance A: IC=1 OC=2 LANES=1 IMG=6
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [35:0] a_img [1];
  logic [8:0]  a_w   [2];
  logic [3:0]  a_thr [2];
  logic [3:0]  a_out [2];
  // Instance B: IC=1 OC=2 LANES=2 IMG=7
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [48:0] b_img [1];
  logic [8:0]  b_w   [2];
  logic [3:0]  b_thr [2];
  logic [3:0]  b_out [2];
  // Instance C: default parameters
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [899:0] c_img [4];
  logic [35:0]  c_w   [8];
  logic [5:0]   c_thr [8];
  logic [195:0] c_out [8];
  logic [195:0] c_exp;
`ifdef BNN_THRESH_FLIP_EN
  logic a_flip [2];
  logic b_flip [2];
  logic c_flip [8];
`endif

  bnn_conv_pool_layer #(.IC(1), .OC(2), .LANES(1), .IMG_IN_SIZE(6)) u_a (
    .clk (clk), .rst_n (rst_n), .in_valid (a_in_valid), .in_ready (a_in_ready),
    .img_in (a_img), .weights (a_w), .thresh (a_thr),
`ifdef BNN_THRESH_FLIP_EN
    .thresh_flip (a_flip),
`endif
    .out_valid (a_out_valid), .out_ready (a_out_ready), .img_out (a_out), .busy (a_busy)
  );

  bnn_conv_pool_layer #(.IC(1), .OC(2), .LANES(2), .IMG_IN_SIZE(7)) u_b (
    .clk (clk), .rst_n (rst_n), .in_valid (b_in_valid), .in_ready (b_in_ready),
    .img_in (b_img), .weights (b_w), .thresh (b_thr),
`ifdef BNN_THRESH_FLIP_EN
    .thresh_flip (b_flip),
`endif
    .out_valid (b_out_valid), .out_ready (b_out_ready), .img_out (b_out), .busy (b_busy)
  );

  bnn_conv_pool_layer #(.IC(4), .OC(8), .LANES(2), .IMG_IN_SIZE(30)) u_c (
    .clk (clk), .rst_n (rst_n), .in_valid (c_in_valid), .in_ready (c_in_ready),
    .img_in (c_img), .weights (c_w), .thresh (c_thr),
`ifdef BNN_THRESH_FLIP_EN
    .thresh_flip (c_flip),
`endif
    .out_valid (c_out_valid), .out_ready (c_out_ready), .img_out (c_out), .busy (c_busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_accept();
    check("a_ready_before_accept", a_in_ready, 1'b1);
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait(input int budget, output int n);
    n = 0;
    while (!a_out_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic a_handshake();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic b_run(output int n);
    check("b_ready_before_accept", b_in_ready, 1'b1);
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic c_accept();
    check("c_ready_before_accept", c_in_ready, 1'b1);
    c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  task automatic c_wait(input int budget, output int n);
    n = 0;
    while (!c_out_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_img[0] = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_img[0] = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_w[i] = '0; a_thr[i] = '0; b_w[i] = '0; b_thr[i] = '0;
    end
    for (int i = 0; i < 4; i++) c_img[i] = '0;
    for (int i = 0; i < 8; i++) begin
      c_w[i] = '0; c_thr[i] = '0;
    end
`ifdef BNN_THRESH_FLIP_EN
    for (int i = 0; i < 2; i++) begin
      a_flip[i] = 1'b0; b_flip[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) c_flip[i] = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_a_in_ready", a_in_ready, 1'b1);
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_out0", a_out[0], 4'h0);
    check("rst_c_in_ready", c_in_ready, 1'b1);
    check("rst_c_busy", c_busy, 1'b0);
    check("rst_c_out7", c_out[7], 196'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A1: all ones, thresh 9 -> every pool cell fires
    a_img[0] = '1; a_w[0] = 9'h1FF; a_w[1] = 9'h1FF; a_thr[0] = 4'd9; a_thr[1] = 4'd9;
    a_accept();
    check("a1_busy", a_busy, 1'b1);
    check("a1_in_ready_compute", a_in_ready, 1'b0);
    a_wait(50, lat);
    check("a1_latency", lat, 8);
    check("a1_out0", a_out[0], 4'b1111);
    check("a1_out1", a_out[1], 4'b1111);
    check("a1_in_ready_done", a_in_ready, 1'b0);
    a_handshake();
    check("a1_out_valid_after_hs", a_out_valid, 1'b0);
    check("a1_in_ready_after_hs", a_in_ready, 1'b1);

    // A2: thresh {10,0}; out_ready held high early must not matter before DONE
    a_thr[0] = 4'd10; a_thr[1] = 4'd0;
    a_out_ready = 1'b1;
    a_accept();
    a_wait(50, lat);
    check("a2_latency", lat, 8);
    check("a2_out0", a_out[0], 4'b0000);
    check("a2_out1", a_out[1], 4'b1111);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("a2_out_valid_after_hs", a_out_valid, 1'b0);

    // A3: ones at (0,0) and (5,5); ch0 kernel (0,0) only, ch1 kernel (2,2) only
    a_img[0] = '0; a_img[0][0] = 1'b1; a_img[0][35] = 1'b1;
    a_w[0] = 9'h001; a_w[1] = 9'h100; a_thr[0] = 4'd9; a_thr[1] = 4'd9;
    a_accept();
    // Changed inputs and in_valid during COMPUTE must be ignored
    a_img[0] = '1; a_w[0] = 9'h1FF; a_thr[0] = 4'd0; a_in_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_wait(50, lat);
    check("a3_latency_rest", lat, 5);
    check("a3_out0", a_out[0], 4'b0001);
    check("a3_out1", a_out[1], 4'b1000);
    a_handshake();

`ifdef BNN_THRESH_FLIP_EN
    // A4: flip on ch1 inverts the comparison
    a_img[0] = '1; a_w[0] = 9'h1FF; a_w[1] = 9'h1FF; a_thr[0] = 4'd9; a_thr[1] = 4'd9;
    a_flip[0] = 1'b0; a_flip[1] = 1'b1;
    a_accept();
    a_wait(50, lat);
    check("a4_flip_latency", lat, 8);
    check("a4_flip_out0", a_out[0], 4'b1111);
    check("a4_flip_out1", a_out[1], 4'b0000);
    a_handshake();
`endif

    // B1: 3x3 block at rows/cols 4..6 only fires conv (4,4), which the floor pool drops
    b_w[0] = 9'h1FF; b_w[1] = 9'h1FF; b_thr[0] = 4'd9; b_thr[1] = 4'd0;
    for (int r = 4; r < 7; r++) for (int c = 4; c < 7; c++) b_img[0][r*7+c] = 1'b1;
    b_run(lat);
    check("b1_latency", lat, 4);
    check("b1_out0", b_out[0], 4'b0000);
    check("b1_out1", b_out[1], 4'b1111);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    // B2: block at rows/cols 3..5 fires conv (3,3) -> pool (1,1)
    b_img[0] = '0;
    for (int r = 3; r < 6; r++) for (int c = 3; c < 6; c++) b_img[0][r*7+c] = 1'b1;
    b_run(lat);
    check("b2_out0", b_out[0], 4'b1000);
    check("b2_out1", b_out[1], 4'b1111);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    // C1: image all ones, ch k kernel has 4k+1 ones; even channels reach threshold
    for (int i = 0; i < 4; i++) c_img[i] = '1;
    for (int ch = 0; ch < 8; ch++) c_w[ch] = (36'd1 << (4 * ch + 1)) - 36'd1;
    c_thr[0] = 6'd1;  c_thr[1] = 6'd6;  c_thr[2] = 6'd9;  c_thr[3] = 6'd14;
    c_thr[4] = 6'd17; c_thr[5] = 6'd22; c_thr[6] = 6'd0;  c_thr[7] = 6'd37;
    c_accept();
    c_wait(2000, lat);
    check("c1_latency", lat, 784);
    for (int ch = 0; ch < 8; ch++) begin
      c_exp = (ch % 2 == 0) ? '1 : '0;
      check($sformatf("c1_out%0d", ch), c_out[ch], c_exp);
    end

    // C1 stall: next bundle offered during DONE, out_ready low for 20 cycles
    for (int i = 0; i < 4; i++) c_img[i] = '0;
    for (int ch = 0; ch < 8; ch++) begin
      c_w[ch] = '0; c_thr[ch] = 6'd36;
    end
    c_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("c_stall_out_valid", c_out_valid, 1'b1);
      check("c_stall_in_ready", c_in_ready, 1'b0);
      check("c_stall_out0", c_out[0], {196{1'b1}});
      check("c_stall_out1", c_out[1], 196'd0);
    end
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    check("c_hs_busy", c_busy, 1'b0);
    check("c_hs_in_ready", c_in_ready, 1'b1);
    check("c_hs_out_valid", c_out_valid, 1'b0);
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    check("c2_accepted_busy", c_busy, 1'b1);
    check("c2_out0_cleared", c_out[0], 196'd0);

    // C2: reset deep into COMPUTE
    repeat (299) @(posedge clk); #1;
    check("c2_busy_mid", c_busy, 1'b1);
    check("c2_partial_out0", c_out[0], {196{1'b1}});
    check("c2_untouched_out7", c_out[7], 196'd0);
    rst_n = 1'b0;
    #1;
    check("c2_rst_busy", c_busy, 1'b0);
    check("c2_rst_in_ready", c_in_ready, 1'b1);
    check("c2_rst_out_valid", c_out_valid, 1'b0);
    check("c2_rst_out0", c_out[0], 196'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // C3: ic0 blocks at rows 0..2/cols 1..3 and rows/cols 27..29; kernel ones on ic0 only
    for (int i = 0; i < 4; i++) c_img[i] = '0;
    for (int r = 0; r < 3; r++) for (int c = 1; c < 4; c++) c_img[0][r*30+c] = 1'b1;
    for (int r = 27; r < 30; r++) for (int c = 27; c < 30; c++) c_img[0][r*30+c] = 1'b1;
    for (int ch = 0; ch < 8; ch++) begin
      c_w[ch] = 36'h1FF;
      c_thr[ch] = (ch % 3 == 0) ? 6'd36 : ((ch % 3 == 1) ? 6'd37 : 6'd27);
    end
    c_accept();
    c_wait(2000, lat);
    check("c3_latency", lat, 784);
    for (int ch = 0; ch < 8; ch++) begin
      if (ch % 3 == 0) begin
        c_exp = '0; c_exp[0] = 1'b1; c_exp[195] = 1'b1;
      end else if (ch % 3 == 1) begin
        c_exp = '0;
      end else begin
        c_exp = '1;
      end
      check($sformatf("c3_out%0d", ch), c_out[ch], c_exp);
    end
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    check("c3_idle_after_hs", c_in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
